// File: rtl/writeback_buffer.sv
// Write-back buffer for the decode-stage register file.
// It queues completed MEM-stage results in a small FIFO and drains one
// register write per cycle. Reads that target a pending write are forwarded
// the newest pending value.
module writeback_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_wen,
    input  logic                       in_mem_sel,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]          in_alu,
    input  logic [DATA_W-1:0]          in_mem,
    input  logic                       drain_en,
    output logic                       r_write,
    output logic [ADDR_W-1:0]          rd,
    output logic [DATA_W-1:0]          w_data,
    input  logic [ADDR_W-1:0]          rs,
    input  logic [ADDR_W-1:0]          rt,
    output logic                       fwd_a_hit,
    output logic [DATA_W-1:0]          fwd_a,
    output logic                       fwd_b_hit,
    output logic [DATA_W-1:0]          fwd_b,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              r_write_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] w_data_q;
    logic              push, pop;

    // A full buffer refuses the handshake even for instructions that write nothing.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid & in_ready & in_wen;
    assign pop      = drain_en & (count_q != '0);

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; validity comes from the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_rd;
            data_q[wr_ptr_q] <= in_mem_sel ? in_mem : in_alu;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            r_write_q <= 1'b0;
            rd_q      <= '0;
            w_data_q  <= '0;
        end else begin
            count_q   <= count_d;
            r_write_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                rd_q     <= addr_q[rd_ptr_q];
                w_data_q <= data_q[rd_ptr_q];
            end
        end
    end

    // Newest-match search: output register first, then FIFO entries from
    // oldest to youngest so that later matches override earlier ones.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] idx);
        logic [DATA_W:0] res;
        logic [PW-1:0]   slot;
        res = '0;
        if (r_write_q && (rd_q == idx)) res = {1'b1, w_data_q};
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[slot] == idx)) res = {1'b1, data_q[slot]};
        end
        return res;
    endfunction

    assign {fwd_a_hit, fwd_a} = lookup(rs);
    assign {fwd_b_hit, fwd_b} = lookup(rt);

    assign r_write = r_write_q;
    assign rd      = rd_q;
    assign w_data  = w_data_q;
    assign count   = count_q;
    assign busy    = (count_q != '0) | r_write_q;

endmodule
